// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and small op-decoding helpers.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'd0;
  localparam logic [1:0] OP_MULT  = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;
  localparam logic [1:0] OP_DIV   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: magnitude/sign extraction of the incoming
// operands, and the final sign correction applied to the raw result in FIX.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [WIDTH-1:0]   mag_a_o,
  output logic [WIDTH-1:0]   mag_b_o,
  output logic               neg_a_o,
  output logic               neg_b_o,
  input  logic [1:0]         fix_op_i,
  input  logic               fix_neg_a_i,
  input  logic               fix_neg_b_i,
  input  logic [2*WIDTH-1:0] raw_i,
  output logic [2*WIDTH-1:0] res_o
);

  // Operand signs only matter for the signed ops; the most-negative value
  // maps onto itself, which is the correct unsigned magnitude.
  always_comb begin
    neg_a_o = is_signed_op(op_i) & a_i[WIDTH-1];
    neg_b_o = is_signed_op(op_i) & b_i[WIDTH-1];
    mag_a_o = neg_a_o ? -a_i : a_i;
    mag_b_o = neg_b_o ? -b_i : b_i;
  end

  // Product negates as one 2*WIDTH value; quotient and remainder negate per half.
  always_comb begin
    res_o = raw_i;
    if (fix_op_i == OP_MULT) begin
      if (fix_neg_a_i ^ fix_neg_b_i) res_o = -raw_i;
    end else if (fix_op_i == OP_DIV) begin
      if (fix_neg_a_i) res_o[2*WIDTH-1:WIDTH] = -raw_i[2*WIDTH-1:WIDTH];
      if (fix_neg_a_i ^ fix_neg_b_i) res_o[WIDTH-1:0] = -raw_i[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit. One shared 2*WIDTH accumulator serves as
// product register (shift-add) and remainder:quotient register (restoring).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; results held
//   ST_RUN  | WIDTH iterations on operand magnitudes
//   ST_FIX  | apply sign / divide-by-zero correction, publish result
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [1:0]         op_q, op_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dz_q, dz_d, done_q, done_d;

  logic               accept;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg_a, neg_b;
  logic [2*WIDTH-1:0] fix_res;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  assign accept = (state_q == ST_IDLE) && start;

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .op_i        (op),
    .a_i         (src_a),
    .b_i         (src_b),
    .mag_a_o     (mag_a),
    .mag_b_o     (mag_b),
    .neg_a_o     (neg_a),
    .neg_b_o     (neg_b),
    .fix_op_i    (op_q),
    .fix_neg_a_i (neg_a_q),
    .fix_neg_b_i (neg_b_q),
    .raw_i       (acc_q),
    .res_o       (fix_res)
  );

  // Single iteration of shift-add multiply and restoring divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    // Shifted remainder needs one extra bit since it can reach 2*divisor-1.
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = rem_sh - {1'b0, b_mag_q};
    div_ge   = (rem_sh >= {1'b0, b_mag_q});
    div_next = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                      : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; the down-counter's terminal count ends RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CW'(1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are taken straight from registers.
  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = done_q;
    hi       = hi_q;
    lo       = lo_q;
    div_zero = dz_q;
  end

  // Datapath next-values: capture on accept, iterate in RUN, publish in FIX.
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_mag_d = b_mag_q;
    a_d     = a_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    if (accept) begin
      cnt_d   = CW'(WIDTH);
      acc_d   = {{WIDTH{1'b0}}, mag_a};
      b_mag_d = mag_b;
      a_d     = src_a;
      op_d    = op;
      neg_a_d = neg_a;
      neg_b_d = neg_b;
    end else if (state_q == ST_RUN) begin
      cnt_d = cnt_q - CW'(1);
      acc_d = is_div_op(op_q) ? div_next : mul_next;
    end else if (state_q == ST_FIX) begin
      done_d = 1'b1;
      if (is_div_op(op_q) && (b_mag_q == '0)) begin
        hi_d = a_q;
        lo_d = '1;
        dz_d = 1'b1;
      end else begin
        hi_d = fix_res[2*WIDTH-1:WIDTH];
        lo_d = fix_res[WIDTH-1:0];
        dz_d = 1'b0;
      end
    end
  end

  // Datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      b_mag_q <= '0;
      a_q     <= '0;
      op_q    <= OP_MULTU;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_mag_q <= b_mag_d;
      a_q     <= a_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

endmodule
